// File: rtl/testio_pkg.sv
// Shared definitions for the single-wire testio link: frame layout, codes, FSM states.
// Both link ends build and decode frames from these constants.
package testio_pkg;

    localparam int BUS_W          = 32;
    localparam int SEL_W          = 4;
    localparam int CNT_W          = 7;
    localparam int CMD_FRAME_BITS = 71;
    localparam int RSP_RD_BITS    = 35;
    localparam int RSP_WR_BITS    = 2;

    localparam logic CMD_RD    = 1'b0;
    localparam logic CMD_WR    = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic ACK_OK    = 1'b0;
    localparam logic ACK_ERR   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_WAIT = 3'd2,
        ST_RX   = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Frame is sent MSB first: start, cmd, addr, sel, wdata, even parity over cmd..wdata.
    function automatic logic [CMD_FRAME_BITS-1:0] build_frame(
        input logic             we,
        input logic [BUS_W-1:0] addr,
        input logic [SEL_W-1:0] sel,
        input logic [BUS_W-1:0] wdata
    );
        logic [CMD_FRAME_BITS-3:0] body;
        body = {(we ? CMD_WR : CMD_RD), addr, sel, (we ? wdata : {BUS_W{1'b0}})};
        return {START_BIT, body, ^body};
    endfunction

endpackage

// File: rtl/testio_if.sv
// Wishbone request/response bundle between the core and the testio master.
// The master modport is the core side; the slave modport is the testio master side.
interface testio_wb_if;
    import testio_pkg::*;

    logic             wbs_cyc_i;
    logic             wbs_stb_i;
    logic             wbs_we_i;
    logic [BUS_W-1:0] wbs_addr_i;
    logic [BUS_W-1:0] wbs_wdata_i;
    logic [SEL_W-1:0] wbs_sel_i;
    logic             wbs_ack_o;
    logic             wbs_err_o;
    logic [BUS_W-1:0] wbs_rdata_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_addr_i, wbs_wdata_i, wbs_sel_i,
        input  wbs_ack_o, wbs_err_o, wbs_rdata_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_addr_i, wbs_wdata_i, wbs_sel_i,
        output wbs_ack_o, wbs_err_o, wbs_rdata_o
    );

endinterface

// File: rtl/testio_serdes.sv
// Link datapath: command PISO (idles high), response SIPO and shared bit/gap counter.
// Load beats shift and clear beats increment; the caller sequences everything.
module testio_serdes
    import testio_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic [CMD_FRAME_BITS-1:0] frame_i,
    input  logic                      tx_shift_i,
    input  logic                      rx_shift_i,
    input  logic                      rx_bit_i,
    input  logic                      cnt_clr_i,
    input  logic                      cnt_inc_i,
    output logic                      dout_o,
    output logic [BUS_W-1:0]          rx_data_o,
    output logic [CNT_W-1:0]          cnt_o
);

    logic [CMD_FRAME_BITS-1:0] piso_q;
    logic [BUS_W-1:0]          sipo_q;
    logic [CNT_W-1:0]          cnt_q;

    // Ones are shifted in behind the frame so the line returns high on its own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            piso_q <= '1;
        end else if (load_i) begin
            piso_q <= frame_i;
        end else if (tx_shift_i) begin
            piso_q <= {piso_q[CMD_FRAME_BITS-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sipo_q <= '0;
        end else if (rx_shift_i) begin
            sipo_q <= {sipo_q[BUS_W-2:0], rx_bit_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (cnt_inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign dout_o    = piso_q[CMD_FRAME_BITS-1];
    assign rx_data_o = sipo_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/testio_master_top.sv
// Wishbone-to-testio bridge: one request at a time, serialised out, response deserialised back.
// Completes with a one-cycle ack or err; new strobes while busy are ignored until completion.
module testio_master_top
    import testio_pkg::*;
#(
    parameter int TI_W        = 1,
    parameter int BUS_WIDTH   = 32,
    parameter int TIMEOUT_CYC = 1024,
    parameter int GAP_CYC     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       test_din,
    output logic       test_dout,
    output logic       test_doen,
    testio_wb_if.slave wb
);

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    generate
        if (TI_W != 1) begin : g_bad_ti_w
            $error("testio_master_top: TI_W must be 1");
        end
        if (BUS_WIDTH != BUS_W) begin : g_bad_bus_width
            $error("testio_master_top: BUS_WIDTH must be 32");
        end
    endgenerate

    state_e             state_q;
    logic               doen_q;
    logic               din_q;
    logic               we_q;
    logic               err_flag_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               ack_q;
    logic               err_q;
    logic [BUS_W-1:0]   rdata_q;

    logic               accept;
    logic               tx_last;
    logic               start_det;
    logic               rx_last;
    logic               gap_last;
    logic               tmo_hit;
    logic               rx_shift;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   rx_len_m1;
    logic [BUS_W-1:0]   rx_data;
    logic [CMD_FRAME_BITS-1:0] frame;

    // Holding off while the completion pulse is up stops a registered core re-issuing its request.
    assign accept    = (state_q == ST_IDLE) && wb.wbs_cyc_i && wb.wbs_stb_i && !ack_q && !err_q;
    assign tx_last   = (state_q == ST_TX) && (cnt == CNT_W'(CMD_FRAME_BITS - 1));
    assign start_det = (state_q == ST_WAIT) && din_q && !test_din;
    assign rx_len_m1 = we_q ? CNT_W'(RSP_WR_BITS - 1) : CNT_W'(RSP_RD_BITS - 1);
    assign rx_last   = (state_q == ST_RX) && (cnt == rx_len_m1);
    assign gap_last  = (state_q == ST_GAP) && (cnt == CNT_W'(GAP_CYC - 1));
    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign rx_shift  = (state_q == ST_RX) && !we_q && (cnt >= CNT_W'(1)) && (cnt <= CNT_W'(BUS_W));
    assign frame     = build_frame(wb.wbs_we_i, wb.wbs_addr_i, wb.wbs_sel_i, wb.wbs_wdata_i);

    testio_serdes u_serdes (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .frame_i    (frame),
        .tx_shift_i (state_q == ST_TX),
        .rx_shift_i (rx_shift),
        .rx_bit_i   (test_din),
        .cnt_clr_i  (accept || tx_last || start_det || rx_last || gap_last),
        .cnt_inc_i  ((state_q == ST_TX) || (state_q == ST_RX) || (state_q == ST_GAP)),
        .dout_o     (test_dout),
        .rx_data_o  (rx_data),
        .cnt_o      (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            doen_q     <= 1'b1;
            din_q      <= 1'b1;
            we_q       <= 1'b0;
            err_flag_q <= 1'b0;
            tmo_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            din_q <= test_din;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q       <= wb.wbs_we_i;
                        err_flag_q <= 1'b0;
                        doen_q     <= 1'b0;
                        state_q    <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (tx_last) begin
                        doen_q  <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (start_det) begin
                        state_q <= ST_RX;
                    end else if (tmo_hit) begin
                        err_flag_q <= 1'b1;
                        state_q    <= ST_GAP;
                    end else if (tmo_q != '1) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_RX: begin
                    if ((cnt == '0) && (test_din != ACK_OK)) begin
                        err_flag_q <= 1'b1;
                    end
                    if (rx_last) begin
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The link frame always runs to the end; only the bus pulse is dropped.
                    if (wb.wbs_cyc_i) begin
                        if (err_flag_q) begin
                            err_q <= 1'b1;
                        end else begin
                            ack_q <= 1'b1;
                            if (!we_q) begin
                                rdata_q <= rx_data;
                            end
                        end
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign test_doen      = doen_q;
    assign wb.wbs_ack_o   = ack_q;
    assign wb.wbs_err_o   = err_q;
    assign wb.wbs_rdata_o = rdata_q;

endmodule

// File: tb/tb_testio_master_top.sv
// Bench for testio_master_top with a behavioural link slave and word memory.
module tb_testio_master_top;
    import testio_pkg::*;

    localparam int TMO  = 1024;
    localparam int GAP  = 4;
    localparam int TURN = 3;

    typedef struct packed {
        logic        is_err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic test_din;
    logic test_dout;
    logic test_doen;

    testio_wb_if wb();

    testio_master_top #(
        .TI_W(1), .BUS_WIDTH(32), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)
    ) dut (
        .clk(clk), .rst(rst), .test_din(test_din), .test_dout(test_dout),
        .test_doen(test_doen), .wb(wb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    exp_t        exp_q[$];
    logic [70:0] frm_q[$];
    logic [31:0] mem[logic [31:0]];
    logic        slv_en = 1'b1;
    logic        slv_force_err = 1'b0;
    logic        slv_glitch = 1'b0;
    logic [70:0] last_frame = '0;
    int          rsp_stop_cyc = 0;
    int          frame_start_cyc = 0;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [70:0] exp_frame(input logic we, input logic [31:0] a,
                                              input logic [3:0] s, input logic [31:0] d);
        logic [68:0] b;
        b = {we, a, s, (we ? d : 32'h0)};
        return {1'b0, b, ^b};
    endfunction

    // Link slave: receives a command frame, answers after TURN cycles.
    initial begin
        test_din = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && test_doen === 1'b0 && test_dout === 1'b0) begin
                logic [70:0] f;
                logic [35:0] rsp;
                logic [31:0] w;
                logic        aborted;
                int          nb;
                f = '0;
                aborted = 1'b0;
                frame_start_cyc = cyc_cnt;
                for (int i = 69; i >= 0; i--) begin
                    test_din = (slv_glitch && i == 40) ? 1'b0 : 1'b1;
                    @(negedge clk);
                    if (rst || test_doen) begin
                        aborted = 1'b1;
                        break;
                    end
                    f[i] = test_dout;
                end
                test_din = 1'b1;
                if (!aborted) begin
                    last_frame = f;
                    if (frm_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL frame_unexpected: got %h want none", f);
                    end else begin
                        chk("cmd_frame", f, frm_q.pop_front());
                    end
                    if (slv_en) begin
                        repeat (TURN) @(negedge clk);
                        w = mem.exists(f[68:37]) ? mem[f[68:37]] : 32'h0;
                        if (f[69]) begin
                            if (!slv_force_err) begin
                                for (int b = 0; b < 4; b++)
                                    if (f[33+b]) w[8*b +: 8] = f[1+8*b +: 8];
                                mem[f[68:37]] = w;
                            end
                            rsp = {1'b0, slv_force_err, 1'b0, 33'h0};
                            nb  = 3;
                        end else begin
                            if (slv_force_err) w = 32'h0BAD_F00D;
                            rsp = {1'b0, slv_force_err, w, 2'b01};
                            nb  = 36;
                        end
                        for (int j = 0; j < nb; j++) begin
                            test_din = rsp[35-j];
                            @(negedge clk);
                        end
                        test_din = 1'b1;
                        rsp_stop_cyc = cyc_cnt;
                        if (slv_glitch) begin
                            @(negedge clk);
                            test_din = 1'b0;
                            @(negedge clk);
                            test_din = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Response monitor: every completion pulse is matched against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (wb.wbs_ack_o || wb.wbs_err_o)) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rsp_unexpected: ack=%b err=%b want none", wb.wbs_ack_o, wb.wbs_err_o);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_err", 71'(wb.wbs_err_o), 71'(e.is_err));
                chk("rsp_ack", 71'(wb.wbs_ack_o), 71'(!e.is_err));
                chk("rsp_rdata", 71'(wb.wbs_rdata_o), 71'(e.rdata));
            end
        end
    end

    task automatic wb_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic exp_err, input logic [31:0] exp_rd,
                          input logic hold);
        int n;
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_addr_i = a; wb.wbs_wdata_i = d; wb.wbs_sel_i = s;
        frm_q.push_back(exp_frame(we, a, s, d));
        exp_q.push_back('{is_err: exp_err, rdata: exp_rd});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wb.wbs_ack_o || wb.wbs_err_o) && n < 3000);
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL wb_complete: got no ack/err after %0d cycles want completion", n);
        end
        if (!hold) begin
            wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        end
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n, c0, c1, stop;
        rst = 1'b1;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_addr_i = '0; wb.wbs_wdata_i = '0; wb.wbs_sel_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_doen", 71'(test_doen), 71'(1));
        chk("rst_dout", 71'(test_dout), 71'(1));
        chk("rst_ack", 71'(wb.wbs_ack_o), 71'(0));
        chk("rst_err", 71'(wb.wbs_err_o), 71'(0));
        chk("rst_rdata", 71'(wb.wbs_rdata_o), 71'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        wb_req(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0);
        chk("wr_mem", 71'(mem[32'h1000_0010]), 71'(32'hDEAD_BEEF));
        chk("wr_frame_head", 71'(last_frame[70:69]), 71'(2'b01));
        chk("wr_parity", 71'(last_frame[0]), 71'(1));

        wb_req(1'b0, 32'h1000_0010, 32'h5555_5555, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0);
        chk("rd_frame_cmd", 71'(last_frame[69]), 71'(0));
        chk("rd_frame_wdata", 71'(last_frame[32:1]), 71'(0));

        wb_req(1'b1, 32'h1000_0010, 32'h1122_3344, 4'b0101, 1'b0, 32'hDEAD_BEEF, 1'b0);
        wb_req(1'b0, 32'h1000_0010, 32'h0, 4'hF, 1'b0, 32'hDE22_BE44, 1'b0);

        // No slave: error must land TIMEOUT + GAP + 1 cycles after the line is released.
        slv_en = 1'b0;
        c0 = 0; c1 = 0;
        fork
            wb_req(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b1, 32'hDE22_BE44, 1'b0);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (test_doen !== 1'b0 && n < 100);
                do begin @(negedge clk); n++; end while (test_doen !== 1'b1 && n < 300);
                c0 = cyc_cnt;
                do begin @(negedge clk); n++; end while (!wb.wbs_err_o && n < 2500);
                c1 = cyc_cnt;
            end
        join
        chk("tmo_latency", 71'(c1 - c0), 71'(TMO + GAP + 1));
        slv_en = 1'b1;

        slv_force_err = 1'b1;
        wb_req(1'b0, 32'h1000_0010, 32'h0, 4'hF, 1'b1, 32'hDE22_BE44, 1'b0);
        wb_req(1'b1, 32'h1000_0010, 32'hCAFE_F00D, 4'hF, 1'b1, 32'hDE22_BE44, 1'b0);
        chk("err_wr_mem", 71'(mem[32'h1000_0010]), 71'(32'hDE22_BE44));
        slv_force_err = 1'b0;

        slv_glitch = 1'b1;
        wb_req(1'b1, 32'h1000_0018, 32'h0123_4567, 4'hF, 1'b0, 32'hDE22_BE44, 1'b0);
        slv_glitch = 1'b0;

        // Reset while bit 30 of a read frame is on the line.
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_addr_i = 32'h1000_0010; wb.wbs_sel_i = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (test_doen !== 1'b0 && n < 20);
        chk("mid_tx_started", 71'(test_doen), 71'(0));
        repeat (30) @(negedge clk);
        #1 rst = 1'b1;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_doen", 71'(test_doen), 71'(1));
        chk("mid_rst_dout", 71'(test_dout), 71'(1));
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        wb_req(1'b0, 32'h1000_0018, 32'h0, 4'hF, 1'b0, 32'h0123_4567, 1'b0);

        wb_req(1'b0, 32'h1000_0010, 32'h0, 4'hF, 1'b0, 32'hDE22_BE44, 1'b1);
        stop = rsp_stop_cyc;
        wb_req(1'b0, 32'h1000_0014, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0);
        chk("b2b_gap_ok", 71'((frame_start_cyc - stop) >= GAP + 2), 71'(1));

        repeat (5) @(negedge clk);
        chk("exp_q_empty", 71'(exp_q.size()), 71'(0));
        chk("frm_q_empty", 71'(frm_q.size()), 71'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
